// File: rtl/ddr_init_seq.sv
// DDR power-up and mode-register init sequencer: CKE bring-up, per-rank MRS chain, ZQCL.
// Define DDR_INIT_RUNTIME_MRS_EN to enable runtime MRS updates once init is done.
module ddr_init_seq #(
  parameter int unsigned NUM_RANKS    = 1,
  parameter int unsigned CAS_DLY      = 4,
  parameter int unsigned WR_DLY       = 10,
  parameter int unsigned RD_DLY       = 13,
  parameter int unsigned AL_DLY       = 0,
  parameter logic [1:0]  BURST_LENGTH = 2'b10,
  parameter int unsigned T_CKE_L      = 10,
  parameter int unsigned T_IS         = 1,
  parameter int unsigned T_XPR        = 5,
  parameter int unsigned T_MRD        = 8,
  parameter int unsigned T_MOD        = 24,
  parameter int unsigned T_ZQ         = 512
) (
  input  logic                 clock_t,
  input  logic                 reset_n,
  output logic                 cke,
  output logic [NUM_RANKS-1:0] cs_sel,
  output logic                 des_rdy,
  output logic                 mrs_rdy,
  output logic                 zqcl_rdy,
  output logic [18:0]          mode_reg,
  output logic [18:0]          mr0,
  output logic                 config_done,
  output logic                 busy,
  input  logic                 upd_req,
  input  logic [2:0]           upd_mr,
  input  logic [14:0]          upd_data,
  output logic                 upd_ack
);

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned T_MAX = max2(max2(max2(T_CKE_L, T_IS), max2(T_XPR, T_MRD)),
                                       max2(T_MOD, T_ZQ));
  localparam int unsigned CNT_W = $clog2(T_MAX) + 1;
  localparam int unsigned RK_W  = (NUM_RANKS > 1) ? $clog2(NUM_RANKS) : 1;

  localparam logic [CNT_W-1:0] TC_CKE = CNT_W'(T_CKE_L - T_IS - 1);
  localparam logic [CNT_W-1:0] TC_IS  = CNT_W'(T_IS);
  localparam logic [CNT_W-1:0] TC_XPR = CNT_W'(T_XPR);
  localparam logic [CNT_W-1:0] TC_MRD = CNT_W'(T_MRD);
  localparam logic [CNT_W-1:0] TC_MOD = CNT_W'(T_MOD);
  localparam logic [CNT_W-1:0] TC_ZQ  = CNT_W'(T_ZQ);
  localparam logic [RK_W-1:0]  LAST_RK = RK_W'(NUM_RANKS - 1);
  localparam logic [NUM_RANKS-1:0] RK_ONE = 1;

  // Mode-register address fields A14:A0
  localparam logic [2:0]  CAS_F = 3'(CAS_DLY - 4);
  localparam logic [2:0]  WR_F  = 3'(WR_DLY - 9);
  localparam logic [3:0]  RD_F  = 4'(RD_DLY - 9);
  localparam logic [1:0]  AL_F  = 2'(AL_DLY);
  localparam logic [14:0] MR0_A = {8'b0, RD_F[3:1], 1'b0, RD_F[0], BURST_LENGTH};
  localparam logic [14:0] MR1_A = {10'b0, AL_F, 2'b0, 1'b1};
  localparam logic [14:0] MR2_A = {9'b0, WR_F, 3'b0};
  localparam logic [14:0] MR4_A = 15'h1800;
  localparam logic [14:0] MR6_A = {2'b0, CAS_F, 10'b0};

  typedef enum logic [3:0] {
    CKE_LOW, CKE_SETUP, XPR_WAIT, MRS_ISSUE, MRS_WAIT,
    MOD_WAIT, ZQCL_ISSUE, ZQ_WAIT, DONE, UPD_ISSUE
  } state_t;

  // Issue order within a rank: MR3, MR6, MR5, MR4, MR2, MR1, MR0
  function automatic logic [2:0] mr_of(input logic [2:0] step);
    case (step)
      3'd0:    return 3'd3;
      3'd1:    return 3'd6;
      3'd2:    return 3'd5;
      3'd3:    return 3'd4;
      3'd4:    return 3'd2;
      3'd5:    return 3'd1;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [14:0] mr_field(input logic [2:0] idx);
    case (idx)
      3'd0:    return MR0_A;
      3'd1:    return MR1_A;
      3'd2:    return MR2_A;
      3'd4:    return MR4_A;
      3'd6:    return MR6_A;
      default: return 15'h0;
    endcase
  endfunction

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [2:0]             step_q, step_d;
  logic [RK_W-1:0]        rank_q, rank_d;
  logic                   upd_q, upd_d;
  logic                   ack_q, ack_d;
  logic [2:0]             umr_q, umr_d;
  logic [14:0]            udata_q, udata_d;
  logic                   cke_q, cke_d;
  logic [NUM_RANKS-1:0]   cs_q, cs_d;
  logic                   des_q, des_d;
  logic                   mrs_q, mrs_d;
  logic                   zq_q, zq_d;
  logic [18:0]            mode_q, mode_d;
  logic [18:0]            mr0_q, mr0_d;
  logic                   done_q, done_d;
  logic                   busy_q, busy_d;
  logic                   upd_go;

`ifdef DDR_INIT_RUNTIME_MRS_EN
  assign upd_go  = upd_req;
  assign upd_ack = ack_q;
`else
  logic unused_upd;
  assign upd_go     = 1'b0;
  assign unused_upd = upd_req;
  assign upd_ack    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    step_d  = step_q;
    rank_d  = rank_q;
    upd_d   = upd_q;
    ack_d   = 1'b0;
    umr_d   = umr_q;
    udata_d = udata_q;
    case (state_q)
      CKE_LOW:
        if (cnt_q == TC_CKE) begin state_d = CKE_SETUP; cnt_d = '0; end
      CKE_SETUP:
        if (cnt_q == TC_IS) begin state_d = XPR_WAIT; cnt_d = '0; end
      XPR_WAIT:
        if (cnt_q == TC_XPR) begin
          state_d = MRS_ISSUE; cnt_d = '0; step_d = '0; rank_d = '0;
        end
      MRS_ISSUE:
        state_d = (step_q == 3'd6) ? MOD_WAIT : MRS_WAIT;
      MRS_WAIT:
        // Update mode reuses this wait: first pass is the ack cycle, later ones honour tMOD
        if (upd_q) begin
          if (ack_q) begin
            state_d = UPD_ISSUE; cnt_d = '0; rank_d = '0;
          end else if (cnt_q == TC_MOD) begin
            if (rank_q == LAST_RK) begin
              state_d = DONE; upd_d = 1'b0;
            end else begin
              state_d = UPD_ISSUE; cnt_d = '0; rank_d = rank_q + 1'b1;
            end
          end
        end else if (cnt_q == TC_MRD) begin
          state_d = MRS_ISSUE; cnt_d = '0; step_d = step_q + 1'b1;
        end
      MOD_WAIT:
        if (cnt_q == TC_MOD) begin state_d = ZQCL_ISSUE; cnt_d = '0; end
      ZQCL_ISSUE:
        state_d = ZQ_WAIT;
      ZQ_WAIT:
        if (cnt_q == TC_ZQ) begin
          if (rank_q == LAST_RK) begin
            state_d = DONE;
          end else begin
            state_d = MRS_ISSUE; cnt_d = '0; step_d = '0; rank_d = rank_q + 1'b1;
          end
        end
      DONE: begin
        cnt_d = '0;
        if (upd_go) begin
          state_d = MRS_WAIT; upd_d = 1'b1; ack_d = 1'b1;
          umr_d = upd_mr; udata_d = upd_data;
        end
      end
      UPD_ISSUE:
        state_d = MRS_WAIT;
      default:
        state_d = CKE_LOW;
    endcase

    // Outputs are registered images of the next state
    cke_d  = (state_d != CKE_LOW);
    des_d  = (state_d inside {XPR_WAIT, MRS_WAIT, MOD_WAIT, ZQ_WAIT});
    mrs_d  = (state_d inside {MRS_ISSUE, UPD_ISSUE});
    zq_d   = (state_d == ZQCL_ISSUE);
    busy_d = (state_d != DONE);
    done_d = done_q | (state_d == DONE);
    cs_d   = '0;
    if (!ack_d && (state_d inside {MRS_ISSUE, MRS_WAIT, MOD_WAIT, ZQCL_ISSUE, ZQ_WAIT, UPD_ISSUE}))
      cs_d = RK_ONE << rank_d;
    mode_d = '0;
    case (state_d)
      MRS_ISSUE:  mode_d = {1'b0, mr_of(step_d), mr_field(mr_of(step_d))};
      UPD_ISSUE:  mode_d = {1'b0, umr_d, udata_d};
      ZQCL_ISSUE: mode_d = '1;
      default:    mode_d = '0;
    endcase
    mr0_d = mr0_q;
    if (mrs_d && (mode_d[17:15] == 3'd0)) mr0_d = mode_d;
  end

  always_ff @(posedge clock_t or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= CKE_LOW;
      cnt_q   <= '0;
      step_q  <= '0;
      rank_q  <= '0;
      upd_q   <= 1'b0;
      ack_q   <= 1'b0;
      umr_q   <= '0;
      udata_q <= '0;
      cke_q   <= 1'b0;
      cs_q    <= '0;
      des_q   <= 1'b0;
      mrs_q   <= 1'b0;
      zq_q    <= 1'b0;
      mode_q  <= '0;
      mr0_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      rank_q  <= rank_d;
      upd_q   <= upd_d;
      ack_q   <= ack_d;
      umr_q   <= umr_d;
      udata_q <= udata_d;
      cke_q   <= cke_d;
      cs_q    <= cs_d;
      des_q   <= des_d;
      mrs_q   <= mrs_d;
      zq_q    <= zq_d;
      mode_q  <= mode_d;
      mr0_q   <= mr0_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign cke         = cke_q;
  assign cs_sel      = cs_q;
  assign des_rdy     = des_q;
  assign mrs_rdy     = mrs_q;
  assign zqcl_rdy    = zq_q;
  assign mode_reg    = mode_q;
  assign mr0         = mr0_q;
  assign config_done = done_q;
  // busy_q resets high so busy asserts the moment reset_n releases, not one edge later
  assign busy        = busy_q & reset_n;

endmodule

// File: tb/tb_ddr_init_seq.sv
// Directed bench for ddr_init_seq: one single-rank and one dual-rank instance on a shared clock/reset.
module tb_ddr_init_seq;
  logic        clock_t = 1'b0;
  logic        reset_n = 1'b0;
  logic        upd_req = 1'b0;
  logic [2:0]  upd_mr = 3'd0;
  logic [14:0] upd_data = 15'h0;

  logic        cke, des_rdy, mrs_rdy, zqcl_rdy, config_done, busy, upd_ack;
  logic [0:0]  cs_sel;
  logic [18:0] mode_reg, mr0;
  logic        cke2, des2, mrs2, zq2, done2, busy2, ack2;
  logic [1:0]  cs_sel2;
  logic [18:0] mode2, mr02;

  int n_chk = 0;
  int n_fail = 0;
  int edge_n = 0;

  always #5 clock_t = ~clock_t;

  ddr_init_seq dut (
    .clock_t(clock_t), .reset_n(reset_n), .cke(cke), .cs_sel(cs_sel),
    .des_rdy(des_rdy), .mrs_rdy(mrs_rdy), .zqcl_rdy(zqcl_rdy),
    .mode_reg(mode_reg), .mr0(mr0), .config_done(config_done), .busy(busy),
    .upd_req(upd_req), .upd_mr(upd_mr), .upd_data(upd_data), .upd_ack(upd_ack)
  );

  ddr_init_seq #(.NUM_RANKS(2)) dut2 (
    .clock_t(clock_t), .reset_n(reset_n), .cke(cke2), .cs_sel(cs_sel2),
    .des_rdy(des2), .mrs_rdy(mrs2), .zqcl_rdy(zq2),
    .mode_reg(mode2), .mr0(mr02), .config_done(done2), .busy(busy2),
    .upd_req(upd_req), .upd_mr(upd_mr), .upd_data(upd_data), .upd_ack(ack2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to edge n (counted from reset release), sampling 1 time unit after each edge
  task automatic adv(input int n);
    while (edge_n < n) begin
      @(posedge clock_t);
      edge_n++;
      #1;
      chk("strobe_onehot", 32'($onehot0({des_rdy, mrs_rdy, zqcl_rdy})), 32'd1);
      chk("strobe_onehot2", 32'($onehot0({des2, mrs2, zq2})), 32'd1);
    end
  endtask

  task automatic release_rst();
    @(negedge clock_t);
    reset_n = 1'b1;
    edge_n = 0;
  endtask

  initial begin
    #1;
    chk("rst_outs", {cke, des_rdy, mrs_rdy, zqcl_rdy, config_done, busy, upd_ack, cs_sel}, 0);
    chk("rst_mode", mode_reg, 0);
    chk("rst_mr0", mr0, 0);
    repeat (2) @(posedge clock_t);
    release_rst();
    #1 chk("busy_at_release", busy, 1);

    adv(8);  chk("cke_e8", cke, 0);
    adv(9);  chk("cke_e9", cke, 1);  chk("des_e9", des_rdy, 0);
    adv(10); chk("des_e10", des_rdy, 0);
    adv(11); chk("des_e11", des_rdy, 1); chk("busy_e11", busy, 1);
    adv(16); chk("mrs_e16", mrs_rdy, 0);
    adv(17); chk("mr3_strobe", mrs_rdy, 1); chk("mr3_des", des_rdy, 0);
             chk("mr3_mode", mode_reg, 19'h18000); chk("mr3_cs", cs_sel, 1);
             chk("mr3_cs2", cs_sel2, 2'b01);
    adv(18); chk("gap_mrs", mrs_rdy, 0); chk("gap_des", des_rdy, 1); chk("gap_mode", mode_reg, 0);
    adv(25); chk("mr6_early", mrs_rdy, 0);
    adv(26); chk("mr6_mode", mode_reg, 19'h30000); chk("mr6_strobe", mrs_rdy, 1);
    adv(35); chk("mr5_mode", mode_reg, 19'h28000);
    adv(44); chk("mr4_mode", mode_reg, 19'h21800);
    adv(53); chk("mr2_mode", mode_reg, 19'h10008);
    adv(62); chk("mr1_mode", mode_reg, 19'h08001);
    adv(70); chk("mr0_pre", mr0, 0);
    adv(71); chk("mr0_mode", mode_reg, 19'h00022); chk("mr0_reg", mr0, 19'h00022);
             chk("mr0_strobe", mrs_rdy, 1);
    adv(95); chk("zq_early", zqcl_rdy, 0);
    adv(96); chk("zq_strobe", zqcl_rdy, 1); chk("zq_mode", mode_reg, 19'h7FFFF);
             chk("zq_cs2", cs_sel2, 2'b01);
    adv(97); chk("zq_end", zqcl_rdy, 0); chk("zq_des", des_rdy, 1); chk("zq_mode0", mode_reg, 0);
    adv(608); chk("done_e608", config_done, 0); chk("busy_e608", busy, 1);
    adv(609); chk("done_e609", config_done, 1); chk("des_done", des_rdy, 0);
              chk("busy_done", busy, 0); chk("cke_done", cke, 1);
              chk("r1_mr3_strobe", mrs2, 1); chk("r1_mr3_mode", mode2, 19'h18000);
              chk("r1_cs2", cs_sel2, 2'b10); chk("r1_done2", done2, 0); chk("r1_busy2", busy2, 1);

    adv(620); upd_mr = 3'd2; upd_data = 15'h0018; upd_req = 1'b1;
    adv(621); upd_req = 1'b0;
    chk("upd_ack2_busy", ack2, 0);
`ifdef DDR_INIT_RUNTIME_MRS_EN
    chk("upd_ack", upd_ack, 1); chk("upd_busy_ack", busy, 1); chk("upd_mrs_ack", mrs_rdy, 0);
    adv(622); chk("upd_strobe", mrs_rdy, 1); chk("upd_mode", mode_reg, 19'h10018);
              chk("upd_ack_end", upd_ack, 0); chk("upd_busy", busy, 1);
              chk("upd_done", config_done, 1); chk("upd_mr0_keep", mr0, 19'h00022);
    adv(646); chk("upd_busy_e646", busy, 1);
    adv(647); chk("upd_busy_e647", busy, 0); chk("upd_done_end", config_done, 1);
`else
    chk("noupd_ack", upd_ack, 0); chk("noupd_busy", busy, 0);
    adv(622); chk("noupd_strobe", {des_rdy, mrs_rdy, zqcl_rdy}, 0); chk("noupd_mode", mode_reg, 0);
              chk("noupd_done", config_done, 1);
    adv(647); chk("noupd_busy_e647", busy, 0);
`endif

    adv(650); upd_mr = 3'd0; upd_data = 15'h0034; upd_req = 1'b1;
    adv(651); upd_req = 1'b0;
    adv(652);
`ifdef DDR_INIT_RUNTIME_MRS_EN
    chk("upd0_mode", mode_reg, 19'h00034); chk("upd0_mr0", mr0, 19'h00034);
`else
    chk("noupd0_mr0", mr0, 19'h00022); chk("noupd0_mrs", mrs_rdy, 0);
`endif

    adv(688);  chk("r1_zq2", zq2, 1); chk("r1_zq_cs2", cs_sel2, 2'b10);
    adv(1200); chk("done2_e1200", done2, 0);
    adv(1201); chk("done2_e1201", done2, 1); chk("busy2_done", busy2, 0);
               chk("cs2_done", cs_sel2, 0); chk("des2_done", des2, 0);
               chk("cke2_done", cke2, 1); chk("mr02_val", mr02, 19'h00022);

    adv(1210);
    reset_n = 1'b0;
    #1 chk("rst2_mr0", mr0, 0); chk("rst2_done", config_done, 0); chk("rst2_cke", cke, 0);
    release_rst();
    adv(35); chk("re_mr5_strobe", mrs_rdy, 1); chk("re_mr5_mode", mode_reg, 19'h28000);
    #2 reset_n = 1'b0;
    #1 chk("abort_outs", {cke, des_rdy, mrs_rdy, zqcl_rdy, config_done, busy, upd_ack, cs_sel}, 0);
       chk("abort_mode", mode_reg, 0);
       chk("abort_outs2", {cke2, des2, mrs2, zq2, done2, busy2, cs_sel2}, 0);
    release_rst();
    adv(8); chk("re_cke_e8", cke, 0);
    adv(9); chk("re_cke_e9", cke, 1);
    adv(11); chk("re_des_e11", des_rdy, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
